// File: rtl/bp_pkg.sv
// Shared types for the dynamic branch predictor: 2-bit counter encodings,
// the saturating counter next-state function and the BTB entry layout.
package bp_pkg;

    localparam int TAG_W = 8;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
    } btb_entry_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        if (taken) begin
            if (c != ST) n = ctr_t'(c + 2'd1);
        end else begin
            if (c != SNT) n = ctr_t'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Tagged branch target buffer: combinational read, negedge write,
// asynchronous clear of the valid bits only.
module bp_btb
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output btb_entry_t          rd_entry,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [31:0]         wr_target
);

    localparam int unsigned DEPTH = 2 ** IDX_BITS;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [TAG_W-1:0] tag_d    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [31:0]      target_d [DEPTH];

    assign rd_entry = '{valid: valid_q[rd_idx], tag: tag_q[rd_idx], target: target_q[rd_idx]};

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en) begin
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = wr_target;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // Tag/target need no reset: they are only observed through a valid bit.
    always_ff @(negedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// IF-stage dynamic branch predictor: 2-bit BHT + tagged BTB, EX-stage update,
// mispredict detection and saturating statistics. Define BP_GSHARE_EN for gshare indexing.
module dynamic_branch_predictor
    import bp_pkg::*;
#(
    parameter int         IDX_BITS = 6,
    parameter int         TAG_BITS = TAG_W,
    parameter int         STAT_W   = 32,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic                CLK,
    input  logic                Reset_L,
    input  logic [31:0]         IF_PC,
    output logic                Pred_Taken,
    output logic [31:0]         Pred_NextPC,
    output logic [IDX_BITS-1:0] Pred_Index,
    input  logic                EX_Update,
    input  logic [31:0]         EX_PC,
    input  logic [IDX_BITS-1:0] EX_Index,
    input  logic                EX_PredTaken,
    input  logic [31:0]         EX_PredNextPC,
    input  logic                EX_Taken,
    input  logic [31:0]         EX_Target,
    output logic                Mispredict,
    output logic [31:0]         Correct_PC,
    output logic [STAT_W-1:0]   Stat_Branches,
    output logic [STAT_W-1:0]   Stat_Mispred
);

    localparam int unsigned DEPTH = 2 ** IDX_BITS;
    localparam int          TAG_HI = IDX_BITS + TAG_BITS + 1;

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    btb_entry_t          rd_entry;
    logic                hit;

    ctr_t              bht_q [DEPTH];
    ctr_t              bht_d [DEPTH];
    logic [STAT_W-1:0] branches_q, branches_d;
    logic [STAT_W-1:0] mispred_q, mispred_d;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC[31:TAG_HI+1], IF_PC[1:0], EX_PC[31:TAG_HI+1], EX_PC[1:0]};

    assign if_idx = IF_PC[IDX_BITS+1:2];
    assign if_tag = IF_PC[TAG_HI:IDX_BITS+2];
    assign ex_idx = EX_PC[IDX_BITS+1:2];
    assign ex_tag = EX_PC[TAG_HI:IDX_BITS+2];

`ifdef BP_GSHARE_EN
    logic [7:0] ghr_q, ghr_d;

    assign Pred_Index = if_idx ^ ghr_q[IDX_BITS-1:0];

    always_comb begin
        ghr_d = ghr_q;
        if (EX_Update) ghr_d = {ghr_q[6:0], EX_Taken};
    end

    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) ghr_q <= '0;
        else          ghr_q <= ghr_d;
    end
`else
    assign Pred_Index = if_idx;
`endif

    bp_btb #(.IDX_BITS(IDX_BITS)) u_btb (
        .clk       (CLK),
        .rst_n     (Reset_L),
        .rd_idx    (if_idx),
        .rd_entry  (rd_entry),
        .wr_en     (EX_Update && EX_Taken),
        .wr_idx    (ex_idx),
        .wr_tag    (ex_tag),
        .wr_target (EX_Target)
    );

    assign hit         = rd_entry.valid && (rd_entry.tag == if_tag);
    assign Pred_Taken  = hit && (bht_q[Pred_Index] inside {WT, ST});
    assign Pred_NextPC = Pred_Taken ? rd_entry.target : IF_PC + 32'd4;

    assign Mispredict = EX_Update &&
                        ((EX_PredTaken != EX_Taken) || (EX_Taken && (EX_PredNextPC != EX_Target)));
    assign Correct_PC = EX_Taken ? EX_Target : EX_PC + 32'd4;

    assign Stat_Branches = branches_q;
    assign Stat_Mispred  = mispred_q;

    always_comb begin
        bht_d      = bht_q;
        branches_d = branches_q;
        mispred_d  = mispred_q;
        if (EX_Update) begin
            bht_d[EX_Index] = ctr_next(bht_q[EX_Index], EX_Taken);
            if (branches_q != '1)              branches_d = branches_q + STAT_W'(1);
            if (Mispredict && mispred_q != '1) mispred_d  = mispred_q + STAT_W'(1);
        end
    end

    always_ff @(negedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int unsigned i = 0; i < DEPTH; i++) bht_q[i] <= ctr_t'(CTR_INIT);
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            bht_q      <= bht_d;
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
        end
    end

endmodule
